noc_port_buffer_bank: RTL and testbench

NOC_PORT_BUFFER_BANK -- requirements
Module: noc_port_buffer_bank

---
 rtl/noc.sv | 17 +
 rtl/noc_port_fifo.sv | 89 ++++++++
 rtl/noc_port_buffer_bank.sv | 43 ++++
 tb/tb_noc_port_buffer_bank.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/noc.sv
// Shared NoC definitions: router port indices and default input-buffer sizing.
package noc;

  // Router port index order, also the slice order of every per-port bus.
  typedef enum logic [2:0] {
    PortN = 3'd0,
    PortS = 3'd1,
    PortW = 3'd2,
    PortE = 3'd3,
    PortP = 3'd4
  } port_e;

  localparam int unsigned MaxPorts         = 5;
  localparam int unsigned DefaultPortDepth = 4;
  localparam int unsigned DefaultStopSlack = 1;

endpackage

// File: rtl/noc_port_fifo.sv
// Single-port flit FIFO with stop/void flow control, occupancy and sticky
// overflow flag.
//
// Handshake: a flit is offered when the sender's void is 0. The upstream
// side transfers a flit on every cycle data_void_in=0 (stop_out is only a
// request to stop; flits still in flight are absorbed by the StopSlack
// reserve, and any flit arriving while full is dropped and flagged). The
// downstream side transfers the head flit on every edge where
// data_void_out=0 and stop_in=0; stop_in is ignored while void.
module noc_port_fifo
  import noc::*;
#(
  parameter int Width     = 66,
  parameter int Depth     = DefaultPortDepth,
  parameter int StopSlack = DefaultStopSlack,
  localparam int PtrW     = $clog2(Depth),
  localparam int CntW     = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] data_in,
  input  logic             data_void_in,
  output logic             stop_out,
  output logic [Width-1:0] data_out,
  output logic             data_void_out,
  input  logic             stop_in,
  output logic [CntW-1:0]  occupancy,
  output logic             overflow_err
);

  localparam logic [CntW-1:0] DepthC     = CntW'(Depth);
  localparam logic [CntW-1:0] StopLevelC = CntW'(Depth - StopSlack);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW-1:0]  wr_ptr;
  logic [CntW-1:0]  count;
  logic [CntW-1:0]  next_count;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign empty = (count == '0);
  assign full  = (count == DepthC);
  // A pop frees the head slot in the same edge, so a full FIFO still
  // accepts a push when the head is leaving.
  assign pop   = !empty && !stop_in;
  assign push  = !data_void_in && (!full || pop);
  assign drop  = !data_void_in && full && !pop;

  assign data_out      = mem[rd_ptr];
  assign data_void_out = empty;
  assign occupancy     = count;

  // Entry count after this edge's push/pop.
  always_comb begin
    next_count = count;
    if (push && !pop) begin
      next_count = count + CntW'(1);
    end else if (!push && pop) begin
      next_count = count - CntW'(1);
    end
  end

  // Pointers, count, registered stop and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      stop_out     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      count    <= next_count;
      stop_out <= (next_count >= StopLevelC);
      if (drop) overflow_err <= 1'b1;
    end
  end

  // Flit storage; contents are meaningless while void, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/noc_port_buffer_bank.sv
// Bank of independent router input buffers, one FIFO per port (N,S,W,E,P).
module noc_port_buffer_bank
  import noc::*;
#(
  parameter int NumPorts  = 5,
  parameter int Width     = 66,
  parameter int Depth     = DefaultPortDepth,
  parameter int StopSlack = DefaultStopSlack,
  localparam int OccW     = $clog2(Depth) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NumPorts*Width-1:0] data_in,
  input  logic [NumPorts-1:0]      data_void_in,
  output logic [NumPorts-1:0]      stop_out,
  output logic [NumPorts*Width-1:0] data_out,
  output logic [NumPorts-1:0]      data_void_out,
  input  logic [NumPorts-1:0]      stop_in,
  output logic [NumPorts*OccW-1:0] occupancy,
  output logic [NumPorts-1:0]      overflow_err
);

  // One FIFO per port; ports share nothing but the clock and reset.
  for (genvar i = 0; i < NumPorts; i++) begin : g_port
    noc_port_fifo #(
      .Width    (Width),
      .Depth    (Depth),
      .StopSlack(StopSlack)
    ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .data_in      (data_in[i*Width +: Width]),
      .data_void_in (data_void_in[i]),
      .stop_out     (stop_out[i]),
      .data_out     (data_out[i*Width +: Width]),
      .data_void_out(data_void_out[i]),
      .stop_in      (stop_in[i]),
      .occupancy    (occupancy[i*OccW +: OccW]),
      .overflow_err (overflow_err[i])
    );
  end

endmodule

// File: tb/tb_noc_port_buffer_bank.sv
// Directed bench for noc_port_buffer_bank (5 ports, Depth 4, StopSlack 1).
module tb_noc_port_buffer_bank;

  localparam int NP = 5;
  localparam int W  = 66;
  localparam int OW = 3;
  localparam int QW = W + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP*W-1:0]  data_in;
  logic [NP-1:0]    data_void_in;
  logic [NP-1:0]    stop_out;
  logic [NP*W-1:0]  data_out;
  logic [NP-1:0]    data_void_out;
  logic [NP-1:0]    stop_in;
  logic [NP*OW-1:0] occupancy;
  logic [NP-1:0]    overflow_err;

  noc_port_buffer_bank dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_void_in (data_void_in),
    .stop_out     (stop_out),
    .data_out     (data_out),
    .data_void_out(data_void_out),
    .stop_in      (stop_in),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  // ---------------- scoreboard ----------------
  logic [QW-1:0] exp_q[$];   // {port[2:0], flit}
  int n_checks = 0;
  int n_fail   = 0;
  logic [NP-1:0] exp_ovf;
  int mon_k;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] occ(input int p);
    return occupancy[p*OW +: OW];
  endfunction

  // Monitor: every head flit that leaves must be the oldest expected flit of its port.
  always @(negedge clk) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        if (!data_void_out[p] && !stop_in[p]) begin
          mon_k = -1;
          for (int j = 0; j < exp_q.size(); j++)
            if (mon_k < 0 && exp_q[j][QW-1:W] == p[2:0]) mon_k = j;
          if (mon_k < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_flit port %0d: got %0h, required none", p, data_out[p*W +: W]);
          end else begin
            check($sformatf("flit_port%0d", p), data_out[p*W +: W], exp_q[mon_k][W-1:0]);
            exp_q.delete(mon_k);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [W-1:0] d, input bit accept);
    logic [2:0] pp;
    pp = p[2:0];
    data_in[p*W +: W] = d;
    data_void_in[p]   = 1'b0;
    if (accept) exp_q.push_back({pp, d});
  endtask

  task automatic idle(input int p);
    data_void_in[p] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b0;
    data_in      = '0;
    data_void_in = '1;
    stop_in      = '0;
    exp_ovf      = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Reset state, no traffic.
    check("rst_void",  data_void_out, 5'b11111);
    check("rst_stop",  stop_out,      5'b00000);
    check("rst_occ",   occupancy,     15'd0);
    check("rst_ovf",   overflow_err,  5'b00000);

    // Port 0: A,B,C held by stop_in; stop_out rises when count reaches 3.
    stop_in[0] = 1'b1;
    drive(0, 66'h0_AAAA_0000_0000_000A, 1'b1); tick();
    check("p0_occ1", occ(0), 3'd1); check("p0_stop1", stop_out[0], 1'b0);
    drive(0, 66'h1_BBBB_0000_0000_000B, 1'b1); tick();
    check("p0_occ2", occ(0), 3'd2); check("p0_stop2", stop_out[0], 1'b0);
    drive(0, 66'h2_CCCC_0000_0000_000C, 1'b1); tick();
    check("p0_occ3", occ(0), 3'd3); check("p0_stop3", stop_out[0], 1'b1);
    idle(0);
    stop_in[0] = 1'b0;
    tick();
    check("p0_occ_drain1", occ(0), 3'd2); check("p0_stop_drain1", stop_out[0], 1'b0);
    tick(); tick();
    check("p0_occ_empty", occ(0), 3'd0);
    check("p0_void_empty", data_void_out[0], 1'b1);

    // Port 2: fill to 4 with stop_in, then a fifth flit is dropped.
    stop_in[2] = 1'b1;
    drive(2, 66'h0_2222_0000_0000_0001, 1'b1); tick();
    drive(2, 66'h0_2222_0000_0000_0002, 1'b1); tick();
    drive(2, 66'h0_2222_0000_0000_0003, 1'b1); tick();
    drive(2, 66'h0_2222_0000_0000_0004, 1'b1); tick();
    check("p2_occ_full", occ(2), 3'd4);
    check("p2_stop_full", stop_out[2], 1'b1);
    check("p2_ovf_before", overflow_err, 5'b00000);
    drive(2, 66'h3_DDDD_DDDD_DDDD_DDDD, 1'b0); tick();
    exp_ovf[2] = 1'b1;
    check("p2_occ_drop", occ(2), 3'd4);
    check("p2_ovf_set", overflow_err, exp_ovf);
    check("others_occ", {occ(4), occ(3), occ(1), occ(0)}, 12'd0);
    idle(2);
    tick();
    check("p2_ovf_sticky", overflow_err, exp_ovf);
    stop_in[2] = 1'b0;
    repeat (4) tick();
    check("p2_occ_drained", occ(2), 3'd0);
    check("p2_ovf_held", overflow_err, exp_ovf);

    // Port 4: full, then simultaneous push and pop for 10 cycles.
    stop_in[4] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(4, 66'h1_4444_0000_0000_0000 + 66'(i), 1'b1); tick();
    end
    check("p4_occ_full", occ(4), 3'd4);
    stop_in[4] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(4, 66'h2_4444_0000_0000_0100 + 66'(i), 1'b1); tick();
      check($sformatf("p4_occ_stream%0d", i), occ(4), 3'd4);
    end
    check("p4_ovf_none", overflow_err, exp_ovf);
    check("p4_stop_stream", stop_out[4], 1'b1);
    idle(4);
    repeat (4) tick();
    check("p4_occ_drained", occ(4), 3'd0);
    check("p4_stop_drained", stop_out[4], 1'b0);

    // Port 1: single flit visible for exactly one cycle.
    check("p1_void_pre", data_void_out[1], 1'b1);
    drive(1, 66'h3_1111_2222_3333_4444, 1'b1); tick();
    check("p1_void_show", data_void_out[1], 1'b0);
    check("p1_occ_show", occ(1), 3'd1);
    idle(1);
    tick();
    check("p1_void_gone", data_void_out[1], 1'b1);
    check("p1_occ_gone", occ(1), 3'd0);

    // All ports hold 2 flits, then asynchronous reset mid-cycle.
    stop_in = '1;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < NP; p++) drive(p, {2'b01, 32'(p), 32'(k)}, 1'b1);
      tick();
    end
    data_void_in = '1;
    check("all_occ2", occupancy, {5{3'd2}});
    check("all_stop2", stop_out, 5'b00000);
    check("all_ovf", overflow_err, exp_ovf);
    #3;
    rst = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = '0;
    check("mid_rst_void", data_void_out, 5'b11111);
    check("mid_rst_occ",  occupancy,     15'd0);
    check("mid_rst_stop", stop_out,      5'b00000);
    check("mid_rst_ovf",  overflow_err,  exp_ovf);
    tick();
    rst     = 1'b1;
    stop_in = '0;
    drive(3, 66'h2_3333_ABCD_EF01_2345, 1'b1); tick();
    check("post_rst_void", data_void_out, 5'b10111);
    check("post_rst_occ3", occ(3), 3'd1);
    idle(3);
    tick();
    check("post_rst_idle", data_void_out, 5'b11111);
    tick();

    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
